// File: rtl/mem_load_stage_pkg.sv
// rtl/mem_load_stage_pkg.sv - shared pipeline types for the memory/load stage
// Purpose: memory-op encoding, stage state enum and default widths shared
// by mem_load_stage and load_align.
// Ports: none (package).
package mem_load_stage_pkg;

  localparam int EXC_W_DEFAULT   = 7;
  localparam int XLEN_DEFAULT    = 32;
  localparam int MAX_OUT_DEFAULT = 2;

  // Access size field of es_mem_op; SIZE_D is only meaningful when XLEN=64.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } mem_size_e;

  // es_mem_op = {sign, size}; sign=1 sign-extends the loaded lane.
  typedef struct packed {
    logic      sign;
    mem_size_e size;
  } mem_op_t;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_READY = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mem_load_stage_load_align.sv
// rtl/mem_load_stage_load_align.sv - load lane select and sign/zero extension
// Purpose: picks the byte/half/word/double lane addressed by addr_lo out of
// the bus word and extends it to XLEN.
// Ports:
//   op       access size and signedness
//   addr_lo  low address bits (size-aligned by the producer)
//   data     raw bus data
//   ext      aligned and extended result
module load_align
  import mem_load_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  mem_op_t           op,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   ext
);

  // On a 32-bit bus only two address bits select a byte lane.
  localparam logic [2:0] LANE_MASK = (XLEN == 64) ? 3'b111 : 3'b011;

  logic [2:0]      off;
  logic [XLEN-1:0] shifted;
  logic            fill;

  always_comb begin
    // Drop the address bits below the access size so the lane is aligned.
    case (op.size)
      SIZE_B:  off = addr_lo;
      SIZE_H:  off = {addr_lo[2:1], 1'b0};
      SIZE_W:  off = {addr_lo[2], 2'b00};
      default: off = 3'b000;
    endcase
    off     = off & LANE_MASK;
    shifted = data >> {off, 3'b000};

    ext  = shifted;
    fill = 1'b0;
    case (op.size)
      SIZE_B: begin
        fill = op.sign & shifted[7];
        for (int i = 8; i < XLEN; i++) ext[i] = fill;
      end
      SIZE_H: begin
        fill = op.sign & shifted[15];
        for (int i = 16; i < XLEN; i++) ext[i] = fill;
      end
      SIZE_W: begin
        fill = op.sign & shifted[31];
        for (int i = 32; i < XLEN; i++) ext[i] = fill;
      end
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_load_stage.sv
// rtl/mem_load_stage.sv - memory/load pipeline stage between EX and WB
// Purpose: holds one instruction, waits for its data-bus response, aligns
// load data and hands the writeback bundle to WB. Responses that belong to
// flushed instructions are counted in discard_cnt and dropped on arrival.
// Ports:
//   clk, reset                            clock, async active-high reset
//   es_to_ms_valid / ms_allowin           EX -> MS handshake
//   es_pc, es_rf_we, es_rf_waddr,
//   es_result, es_res_from_mem,
//   es_mem_op, es_mem_req, es_except      EX instruction bundle
//   es_req_outstanding                    EX holds an unanswered bus request
//   data_ok / rdata                       data-bus response
//   except_flush                          pipeline flush
//   ws_allowin / ms_to_ws_valid           MS -> WB handshake
//   ms_rf_we / ms_rf_waddr / ms_rf_wdata  writeback bundle
//   ms_pc / ms_except / vaddr             registered PC, exceptions, address
module mem_load_stage
  import mem_load_stage_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int EXC_W   = EXC_W_DEFAULT,
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_to_ms_valid,
  output logic             ms_allowin,
  input  logic [31:0]      es_pc,
  input  logic             es_rf_we,
  input  logic [4:0]       es_rf_waddr,
  input  logic [XLEN-1:0]  es_result,
  input  logic             es_res_from_mem,
  input  logic [2:0]       es_mem_op,
  input  logic             es_mem_req,
  input  logic             es_req_outstanding,
  input  logic [EXC_W-1:0] es_except,
  input  logic             data_ok,
  input  logic [XLEN-1:0]  rdata,
  input  logic             except_flush,
  input  logic             ws_allowin,
  output logic             ms_to_ws_valid,
  output logic             ms_rf_we,
  output logic [4:0]       ms_rf_waddr,
  output logic [XLEN-1:0]  ms_rf_wdata,
  output logic [31:0]      ms_pc,
  output logic [EXC_W-1:0] ms_except,
  output logic [XLEN-1:0]  vaddr
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_OUT);

  ms_state_e        state, state_nxt;
  logic [CNT_W-1:0] discard_cnt, discard_nxt;

  logic [31:0]      pc_q;
  logic [EXC_W-1:0] except_q;
  logic [XLEN-1:0]  res_q;
  logic [XLEN-1:0]  data_q;
  logic             rf_we_q;
  logic [4:0]       waddr_q;
  logic             from_mem_q;
  mem_op_t          op_q;

  logic             ms_ready_go;
  logic             accept;
  logic             es_needs_data;
  logic             dok_free;
  logic             dok_drop;
  logic             accept_bypass;
  logic             pend_lost;
  logic [SUM_W-1:0] disc_add;
  logic [SUM_W-1:0] disc_sum;
  logic             disc_ovf;
  logic [XLEN-1:0]  align_in;
  logic [XLEN-1:0]  align_out;

  // A response with no discards ahead of it belongs to the live instruction.
  assign dok_free      = data_ok & (discard_cnt == '0);
  assign dok_drop      = data_ok & (discard_cnt != '0);
  assign es_needs_data = es_mem_req & (es_except == '0);
  assign accept        = es_to_ms_valid & ms_allowin & ~except_flush;
  // Outside WAIT a free response can only answer the instruction entering now.
  assign accept_bypass = accept & es_needs_data & dok_free & (state != MS_WAIT);

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MS_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (except_flush) begin
      state_nxt = MS_EMPTY;
    end else if (accept) begin
      state_nxt = (es_needs_data & ~accept_bypass) ? MS_WAIT : MS_READY;
    end else if (ms_to_ws_valid & ws_allowin) begin
      state_nxt = MS_EMPTY;
    end else if ((state == MS_WAIT) & dok_free) begin
      state_nxt = MS_READY;
    end
  end

  always_comb begin
    ms_ready_go    = (state == MS_READY) | ((state == MS_WAIT) & dok_free);
    ms_allowin     = (state == MS_EMPTY) | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ((state == MS_READY) | (state == MS_WAIT)) & ms_ready_go;
    ms_rf_we       = (state != MS_EMPTY) & rf_we_q;
  end

  // ------------------------------------------------------- discard counter
  // A flushed WAIT whose response has not been consumed this cycle leaves
  // one response in flight; so does an outstanding EX request. A response
  // dropped this cycle is taken off in the same update.
  always_comb begin
    pend_lost   = (state == MS_WAIT) & ~dok_free;
    disc_add    = SUM_W'(pend_lost) + SUM_W'(es_req_outstanding);
    disc_sum    = SUM_W'(discard_cnt) + (except_flush ? disc_add : '0)
                  - SUM_W'(dok_drop);
    disc_ovf    = disc_sum > MAX_SUM;
    discard_nxt = disc_ovf ? CNT_W'(MAX_OUT) : disc_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard_cnt <= '0;
    end else begin
      discard_cnt <= discard_nxt;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!disc_ovf) else $error("mem_load_stage: discard_cnt overflow");
    end
  end
`endif

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      except_q   <= '0;
      res_q      <= '0;
      data_q     <= '0;
      rf_we_q    <= 1'b0;
      waddr_q    <= '0;
      from_mem_q <= 1'b0;
      op_q       <= '0;
    end else begin
      if (accept) begin
        pc_q       <= es_pc;
        except_q   <= es_except;
        res_q      <= es_result;
        rf_we_q    <= es_rf_we;
        waddr_q    <= es_rf_waddr;
        from_mem_q <= es_res_from_mem;
        op_q       <= mem_op_t'(es_mem_op);
      end
      // Raw response is kept so READY can re-run alignment on it.
      if (dok_free & ((state == MS_WAIT) | accept_bypass)) begin
        data_q <= rdata;
      end
    end
  end

  // In WAIT the only valid data is the live bus response (bypass).
  assign align_in = (state == MS_WAIT) ? rdata : data_q;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .op      (op_q),
    .addr_lo (res_q[2:0]),
    .data    (align_in),
    .ext     (align_out)
  );

  assign ms_rf_wdata = from_mem_q ? align_out : res_q;
  assign ms_rf_waddr = waddr_q;
  assign ms_pc       = pc_q;
  assign ms_except   = except_q;
  assign vaddr       = res_q;

endmodule

// File: tb/tb_mem_load_stage.sv
// tb/tb_mem_load_stage.sv - self-checking bench for mem_load_stage (XLEN 32 and 64)
module tb_mem_load_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid, es_rf_we, es_res_from_mem, es_mem_req;
  logic        es_req_outstanding, data_ok, except_flush, ws_allowin;
  logic [31:0] es_pc;
  logic [4:0]  es_rf_waddr;
  logic [63:0] es_result, rdata;
  logic [2:0]  es_mem_op;
  logic [6:0]  es_except;

  logic        allowin32, valid32, we32;
  logic [4:0]  waddr32;
  logic [31:0] wdata32, pc32, vaddr32;
  logic [6:0]  exc32;
  logic        allowin64, valid64, we64;
  logic [4:0]  waddr64;
  logic [63:0] wdata64, vaddr64;
  logic [31:0] pc64;
  logic [6:0]  exc64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_load_stage #(.XLEN(32), .EXC_W(7), .MAX_OUT(2)) u_dut32 (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(allowin32),
    .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_result(es_result[31:0]),
    .es_res_from_mem(es_res_from_mem), .es_mem_op(es_mem_op), .es_mem_req(es_mem_req),
    .es_req_outstanding(es_req_outstanding), .es_except(es_except), .data_ok(data_ok),
    .rdata(rdata[31:0]), .except_flush(except_flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(valid32), .ms_rf_we(we32), .ms_rf_waddr(waddr32), .ms_rf_wdata(wdata32),
    .ms_pc(pc32), .ms_except(exc32), .vaddr(vaddr32)
  );

  mem_load_stage #(.XLEN(64), .EXC_W(7), .MAX_OUT(2)) u_dut64 (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(allowin64),
    .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_result(es_result),
    .es_res_from_mem(es_res_from_mem), .es_mem_op(es_mem_op), .es_mem_req(es_mem_req),
    .es_req_outstanding(es_req_outstanding), .es_except(es_except), .data_ok(data_ok),
    .rdata(rdata), .except_flush(except_flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(valid64), .ms_rf_we(we64), .ms_rf_waddr(waddr64), .ms_rf_wdata(wdata64),
    .ms_pc(pc64), .ms_except(exc64), .vaddr(vaddr64)
  );

  // Reference model: one instruction slot plus a FIFO of in-flight bus
  // responses, each tagged as belonging to the slot (1) or to be dropped (0).
  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] res;
    logic        from_mem;
    logic [2:0]  op;
    logic        needs;
    logic [6:0]  exc;
    logic        has;
    logic [63:0] data;
  } slot_t;

  slot_t slot;
  bit    slot_v = 1'b0;
  bit    bus_q[$];

  function automatic logic [63:0] ref_ext(input int xlen, input logic [2:0] op,
                                          input logic [63:0] addr, input logic [63:0] data);
    int          nb, off;
    logic [63:0] v, mask;
    nb   = 1 << op[1:0];
    off  = int'(addr[2:0]) % (xlen / 8);
    off  = off - (off % nb);
    v    = data >> (off * 8);
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
    v    = v & mask;
    if (op[2] && nb < 8 && v[nb*8-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit          dok_slot, ready;
    logic [63:0] cur;
    dok_slot = data_ok && bus_q.size() > 0 && bus_q[0];
    ready    = slot_v && (!slot.needs || slot.has || dok_slot);
    chk("valid32", valid32, ready);
    chk("valid64", valid64, ready);
    chk("allowin32", allowin32, !slot_v || (ready && ws_allowin));
    chk("allowin64", allowin64, !slot_v || (ready && ws_allowin));
    chk("we32", we32, slot_v && slot.we);
    chk("we64", we64, slot_v && slot.we);
    if (slot_v) begin
      chk("pc32", pc32, slot.pc);
      chk("pc64", pc64, slot.pc);
      chk("exc32", exc32, slot.exc);
      chk("exc64", exc64, slot.exc);
      chk("waddr32", waddr32, slot.waddr);
      chk("waddr64", waddr64, slot.waddr);
      chk("vaddr32", vaddr32, slot.res[31:0]);
      chk("vaddr64", vaddr64, slot.res);
    end
    if (ready && (!slot.from_mem || slot.needs)) begin
      cur = slot.has ? slot.data : rdata;
      chk("wdata64", wdata64, slot.from_mem ? ref_ext(64, slot.op, slot.res, cur) : slot.res);
      if (!(slot.from_mem && slot.op[1:0] == 2'b11))
        chk("wdata32", wdata32,
            slot.from_mem ? ref_ext(32, slot.op, slot.res, cur) : {32'd0, slot.res[31:0]});
    end
  endtask

  task automatic model_step();
    bit dok_slot, ready, handoff;
    dok_slot = data_ok && bus_q.size() > 0 && bus_q[0];
    ready    = slot_v && (!slot.needs || slot.has || dok_slot);
    handoff  = ready && ws_allowin;
    if (data_ok && bus_q.size() > 0) begin
      void'(bus_q.pop_front());
      if (dok_slot) begin
        slot.has  = 1'b1;
        slot.data = rdata;
      end
    end
    if (except_flush) begin
      slot_v = 1'b0;
      foreach (bus_q[i]) bus_q[i] = 1'b0;
      if (es_req_outstanding) bus_q.push_back(1'b0);
    end else if (es_to_ms_valid && (!slot_v || handoff)) begin
      slot_v        = 1'b1;
      slot.pc       = es_pc;
      slot.we       = es_rf_we;
      slot.waddr    = es_rf_waddr;
      slot.res      = es_result;
      slot.from_mem = es_res_from_mem;
      slot.op       = es_mem_op;
      slot.exc      = es_except;
      slot.needs    = es_mem_req && (es_except == 7'd0);
      slot.has      = 1'b0;
      if (slot.needs) bus_q.push_back(1'b1);
    end else if (handoff) begin
      slot_v = 1'b0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    es_to_ms_valid = 0; es_rf_we = 0; es_res_from_mem = 0; es_mem_req = 0;
    es_req_outstanding = 0; data_ok = 0; except_flush = 0; ws_allowin = 1;
    es_pc = 0; es_rf_waddr = 0; es_result = 0; rdata = 0; es_mem_op = 0; es_except = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [63:0] res, input logic [2:0] op,
                       input logic req, input logic from_mem, input logic [6:0] exc);
    es_to_ms_valid = 1; es_pc = pc; es_result = res; es_mem_op = op; es_mem_req = req;
    es_res_from_mem = from_mem; es_except = exc; es_rf_we = 1; es_rf_waddr = pc[6:2];
  endtask

  task automatic gen_inputs();
    int kind, avail, nb;
    data_ok      = (bus_q.size() > 0) && ($urandom_range(0, 2) != 0);
    rdata        = {$urandom, $urandom};
    ws_allowin   = ($urandom_range(0, 3) != 0);
    except_flush = ($urandom_range(0, 11) == 0);
    avail        = bus_q.size() - (data_ok ? 1 : 0);
    es_req_outstanding = except_flush && (avail < 2) && ($urandom_range(0, 1) == 1);
    es_to_ms_valid = ($urandom_range(0, 3) != 0);
    es_pc        = $urandom;
    es_rf_we     = $urandom_range(0, 1);
    es_rf_waddr  = $urandom_range(0, 31);
    kind         = $urandom_range(0, 3);
    if (kind != 0 && avail >= 2) kind = 0;
    es_mem_op    = $urandom_range(0, 7);
    nb           = 1 << es_mem_op[1:0];
    es_result    = {$urandom, $urandom} & ~(64'(nb) - 64'd1);
    es_mem_req   = (kind != 0);
    es_res_from_mem = (kind == 1) || (kind == 3);
    es_except    = (kind == 3) ? 7'(($urandom_range(0, 6) == 0) ? 7'h04 : 7'($urandom_range(1, 127))) : 7'd0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid32", valid32, 0);   chk("rst_valid64", valid64, 0);
    chk("rst_we32", we32, 0);         chk("rst_we64", we64, 0);
    chk("rst_pc32", pc32, 0);         chk("rst_exc64", exc64, 0);
    chk("rst_vaddr64", vaddr64, 0);   chk("rst_wdata64", wdata64, 0);
    chk("rst_allowin32", allowin32, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // ld.b at 0x3, response one cycle after acceptance
    offer(32'h100, 64'h3, 3'b100, 1, 1, 7'd0);
    at_neg(); at_pos();
    idle_inputs();
    data_ok = 1; rdata = 64'h1122_3344_80AB_CDEF;
    at_neg();
    chk("ldb_wdata32", wdata32, 32'hFFFF_FF80);
    chk("ldb_wdata64", wdata64, 64'hFFFF_FFFF_FFFF_FF80);
    chk("ldb_valid32", valid32, 1);
    at_pos();

    // ld.hu at 0x2 with WB stalled for 3 cycles
    idle_inputs();
    offer(32'h104, 64'h2, 3'b001, 1, 1, 7'd0);
    at_neg(); at_pos();
    idle_inputs();
    ws_allowin = 0; data_ok = 1; rdata = 64'h5555_6666_BEEF_1234;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("ldhu_wdata32", wdata32, 32'h0000_BEEF);
      chk("ldhu_wdata64", wdata64, 64'h0000_0000_0000_BEEF);
      chk("ldhu_allowin", allowin32, 0);
      at_pos();
      data_ok = 0; rdata = {$urandom, $urandom};
    end
    ws_allowin = 1;
    at_neg();
    chk("ldhu_release", allowin32, 1);
    at_pos();

    // flush in WAIT with an outstanding EX request: two responses dropped
    idle_inputs();
    offer(32'h200, 64'h8, 3'b010, 1, 1, 7'd0);
    at_neg(); at_pos();
    idle_inputs();
    except_flush = 1; es_req_outstanding = 1;
    at_neg(); at_pos();
    idle_inputs();
    offer(32'h300, 64'h4, 3'b010, 1, 1, 7'd0);
    at_neg(); at_pos();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      data_ok = 1; rdata = 64'hCAFE_F00D_1234_5678;
      at_neg();
      chk("discard_valid", valid32, (i == 2));
      if (i == 2) chk("discard_wdata32", wdata32, 32'h1234_5678);
      at_pos();
    end
    idle_inputs();

    // back-to-back ALU ops
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 4) offer(32'h400 + 32'(4 * i), 64'(32'hA000 + i), 3'b000, 0, 0, 7'd0);
      at_neg();
      if (i > 0) begin
        chk("b2b_pc", pc32, 32'h400 + 32'(4 * (i - 1)));
        chk("b2b_valid", valid32, 1);
        chk("b2b_allowin", allowin32, 1);
      end
      at_pos();
    end

    // load carrying an exception skips WAIT
    idle_inputs();
    offer(32'h500, 64'h10, 3'b110, 1, 1, 7'h04);
    at_neg(); at_pos();
    idle_inputs();
    at_neg();
    chk("exc_valid", valid64, 1);
    chk("exc_vec", exc32, 7'h04);
    at_pos();

    // ld.d on XLEN=64, then reset during WAIT
    idle_inputs();
    offer(32'h600, 64'h0, 3'b011, 1, 1, 7'd0);
    at_neg(); at_pos();
    idle_inputs();
    data_ok = 1; rdata = 64'h0123_4567_89AB_CDEF;
    at_neg();
    chk("ldd_wdata64", wdata64, 64'h0123_4567_89AB_CDEF);
    at_pos();
    idle_inputs();
    offer(32'h608, 64'h8, 3'b011, 1, 1, 7'd0);
    at_neg(); at_pos();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid64", valid64, 0);  chk("arst_we64", we64, 0);
    chk("arst_pc64", pc64, 0);        chk("arst_exc64", exc64, 0);
    chk("arst_vaddr64", vaddr64, 0);  chk("arst_wdata64", wdata64, 0);
    chk("arst_waddr64", waddr64, 0);  chk("arst_allowin64", allowin64, 1);
    chk("arst_valid32", valid32, 0);
    slot_v = 1'b0;
    bus_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      gen_inputs();
      at_neg();
      at_pos();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
